// File: rtl/midi_btn_encoder_if.sv
// Byte stream from the button encoder to the MIDI serializer.
// A byte transfers on a clk edge where byte_valid and byte_ready are both high.
interface midi_btn_encoder_if;
   logic [7:0] byte_data;
   logic       byte_valid;
   logic       byte_ready;

   modport master (
      output byte_data,
      output byte_valid,
      input  byte_ready
   );

   modport slave (
      input  byte_data,
      input  byte_valid,
      output byte_ready
   );
endinterface

// File: rtl/midi_btn_encoder.sv
// Debounces raw buttons and emits a MIDI Control Change message for every
// accepted press (value 127) or release (value 0) over a valid/ready byte stream.
module midi_btn_encoder #(
   parameter int unsigned NUM_BTNS     = 4,
   parameter int unsigned DEBOUNCE_CNT = 1_000_000,
   parameter logic [3:0]  CHANNEL      = 4'h0,
   parameter int unsigned FIRST_CC     = 46,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_BTNS-1:0] btn,
   midi_btn_encoder_if.master  tx,
   output logic                busy,
   output logic                overflow
);

   localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CNT);
   localparam int unsigned IDX_W  = (NUM_BTNS > 1) ? $clog2(NUM_BTNS) : 1;
   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned PTR_W1 = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CNT - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_STATUS = 2'd1;
   localparam logic [1:0] S_DATA1  = 2'd2;
   localparam logic [1:0] S_DATA2  = 2'd3;

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic             val;
   } evt_t;

   logic [NUM_BTNS-1:0] sync_meta;
   logic [NUM_BTNS-1:0] sync;
   logic [NUM_BTNS-1:0] stable;
   logic [CNT_W-1:0]    cnt [NUM_BTNS];
   logic [NUM_BTNS-1:0] raise;
   logic [NUM_BTNS-1:0] pend;
   logic [NUM_BTNS-1:0] pval;
   logic [NUM_BTNS-1:0] grant;
   logic                push;
   logic [IDX_W-1:0]    push_idx;

   evt_t                mem [FIFO_DEPTH];
   logic [PTR_W:0]      wr_ptr, wr_ptr_d;
   logic [PTR_W:0]      rd_ptr, rd_ptr_d;
   logic                full, empty;
   evt_t                head;

   logic [1:0]          state, state_d;
   logic                pop;
   logic [7:0]          byte_q, byte_d;
   logic                valid_q, valid_d;
   logic                busy_d;
   logic [IDX_W-1:0]    hold_idx;
   logic                hold_val;

   // Two-flop synchroniser for the asynchronous button levels
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_meta <= '0;
         sync      <= '0;
      end else begin
         sync_meta <= btn;
         sync      <= sync_meta;
      end
   end

   always_comb begin
      raise = '0;
      for (int i = 0; i < NUM_BTNS; i++)
         raise[i] = (sync[i] != stable[i]) && (cnt[i] == CNT_MAX);
   end

   // A new level is accepted only after it has persisted DEBOUNCE_CNT cycles
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stable <= '0;
         for (int i = 0; i < NUM_BTNS; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_BTNS; i++) begin
            if (sync[i] == stable[i]) begin
               cnt[i] <= '0;
            end else if (raise[i]) begin
               cnt[i]    <= '0;
               stable[i] <= sync[i];
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Lowest-index pending button wins the single push slot
   always_comb begin
      push     = 1'b0;
      push_idx = '0;
      if (!full) begin
         for (int i = NUM_BTNS - 1; i >= 0; i--) begin
            if (pend[i]) begin
               push     = 1'b1;
               push_idx = IDX_W'(i);
            end
         end
      end
      grant = NUM_BTNS'(push) << push_idx;
   end

   // A raise on the same edge as the button's push re-arms pend, so nothing is lost
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend     <= '0;
         pval     <= '0;
         overflow <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_BTNS; i++) begin
            if (raise[i]) begin
               pend[i] <= 1'b1;
               pval[i] <= sync[i];
            end else if (grant[i]) begin
               pend[i] <= 1'b0;
            end
         end
         if (|(raise & pend & ~grant)) overflow <= 1'b1;
      end
   end

   assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign empty = (wr_ptr == rd_ptr);
   assign head  = mem[rd_ptr[PTR_W-1:0]];

   assign wr_ptr_d = wr_ptr + PTR_W1'(push);
   assign rd_ptr_d = rd_ptr + PTR_W1'(pop);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[PTR_W-1:0]] <= '{idx: push_idx, val: pval[push_idx]};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         wr_ptr <= wr_ptr_d;
         rd_ptr <= rd_ptr_d;
      end
   end

   // Output sequencer: IDLE pops an event, then status / controller / value bytes
   always_comb begin
      state_d = state;
      pop     = 1'b0;
      byte_d  = byte_q;
      valid_d = valid_q;
      case (state)
         S_IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               state_d = S_STATUS;
               valid_d = 1'b1;
               byte_d  = {4'hB, CHANNEL};
            end
         end
         S_STATUS: begin
            if (tx.byte_ready) begin
               state_d = S_DATA1;
               byte_d  = {1'b0, 7'(FIRST_CC + 32'(hold_idx))};
            end
         end
         S_DATA1: begin
            if (tx.byte_ready) begin
               state_d = S_DATA2;
               byte_d  = hold_val ? 8'd127 : 8'd0;
            end
         end
         S_DATA2: begin
            if (tx.byte_ready) begin
               state_d = S_IDLE;
               valid_d = 1'b0;
               byte_d  = 8'd0;
            end
         end
         default: begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            byte_d  = 8'd0;
         end
      endcase
      busy_d = (state_d != S_IDLE) || (wr_ptr_d != rd_ptr_d);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         byte_q   <= 8'd0;
         valid_q  <= 1'b0;
         busy     <= 1'b0;
         hold_idx <= '0;
         hold_val <= 1'b0;
      end else begin
         byte_q  <= byte_d;
         valid_q <= valid_d;
         busy    <= busy_d;
         if (pop) begin
            hold_idx <= head.idx;
            hold_val <= head.val;
         end
      end
   end

   assign tx.byte_data  = byte_q;
   assign tx.byte_valid = valid_q;

endmodule
